// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared constants, width helper and one-hot vector type for the binary
//   one-hot decoder family (decoder_2to4 and its onehot_check helper).
//
//   DEC_IN_W_DEFAULT  : default select width (2 -> 4-bit one-hot)
//   dec_out_w(in_w)   : one-hot width for a given select width (2**in_w)
//   dec_onehot_t      : one-hot vector type at the default width
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int DEC_IN_W_DEFAULT = 2;

    // Every select value maps to exactly one output bit, so the output width
    // is always a full power of two and there are no out-of-range selects.
    function automatic int dec_out_w(input int in_w);
        return 1 << in_w;
    endfunction

    localparam int DEC_OUT_W_DEFAULT = 1 << DEC_IN_W_DEFAULT;

    typedef logic [DEC_OUT_W_DEFAULT-1:0] dec_onehot_t;

endpackage : decoder_pkg

// File: rtl/decoder_2to4_onehot_check.sv
// -----------------------------------------------------------------------------
// onehot_check
//   Combinational one-hot integrity check. Flags a vector whose population
//   count is not exactly one while the check is enabled.
//
//   Parameters:
//     W       : vector width
//   Ports:
//     vec     in   W   vector under test
//     chk_en  in   1   check qualifier (vector is meaningful this cycle)
//     err     out  1   chk_en && popcount(vec) != 1
// -----------------------------------------------------------------------------
module onehot_check
    import decoder_pkg::*;
#(
    parameter int W = DEC_OUT_W_DEFAULT
) (
    input  logic [W-1:0] vec,
    input  logic         chk_en,
    output logic         err
);

    // Both the all-zero vector and any multi-hot vector are errors.
    assign err = chk_en && ($countones(vec) != 1);

endmodule : onehot_check

// File: rtl/decoder_2to4.sv
// -----------------------------------------------------------------------------
// decoder_2to4
//   Binary-to-one-hot decoder with an input valid qualifier and an output
//   valid flag aligned with the decoded data. Used as a generic address/select
//   decode primitive (chip selects, mux steering).
//
//   Parameters:
//     IN_W     : select width in bits, legal range 1..6
//     OUT_W    : one-hot width, derived as 2**IN_W (do not override)
//     REG_OUT  : 1 = registered output, 1-cycle latency
//                0 = combinational pass-through (reset has no effect on it)
//
//   Ports:
//     clk         in   1      rising-edge clock
//     rst_n       in   1      asynchronous active-low reset
//     in_valid    in   1      qualifies in for decode this cycle
//     in          in   IN_W   binary select value, unsigned
//     out         out  OUT_W  one-hot decode, bit[in] set
//     out_valid   out  1      out holds a freshly decoded value
//     onehot_err  out  1      (DECODER_ONEHOT_CHK_EN only) sticky flag, set
//                             when out_valid=1 and out is not one-hot
//
//   Build option:
//     DECODER_ONEHOT_CHK_EN  : adds the onehot_err port and its checker.
//
//   Handshake: in_valid/out_valid are pure qualifiers with no ready. Every
//   cycle with in_valid=1 produces exactly one out_valid=1 cycle (next cycle
//   when registered, same cycle when combinational); there is no backpressure
//   and back-to-back inputs decode without bubbles.
// -----------------------------------------------------------------------------
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int IN_W    = DEC_IN_W_DEFAULT,
    parameter int OUT_W   = dec_out_w(IN_W),
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
`ifdef DECODER_ONEHOT_CHK_EN
    ,
    output logic             onehot_err
`endif
);

    // Raw decode of the current select, independent of the qualifier.
    logic [OUT_W-1:0] dec_vec;

    assign dec_vec = {{(OUT_W-1){1'b0}}, 1'b1} << in;

    if (REG_OUT) begin : g_reg
        logic [OUT_W-1:0] out_q;
        logic             valid_q;

        // out_q keeps its last decode through idle cycles; only valid_q
        // tells the consumer whether it is fresh. Reset clears both, which
        // also drops any decode that was captured just before reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    out_q <= dec_vec;
                end
            end
        end

        assign out       = out_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        // Unlike the registered path, idle cycles present all-zero here.
        assign out       = in_valid ? dec_vec : '0;
        assign out_valid = in_valid;
    end

`ifdef DECODER_ONEHOT_CHK_EN
    logic chk_err;

    onehot_check #(
        .W (OUT_W)
    ) u_onehot_check (
        .vec    (out),
        .chk_en (out_valid),
        .err    (chk_err)
    );

    // Sticky until reset so a single bad cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else if (chk_err) begin
            onehot_err <= 1'b1;
        end
    end
`endif

endmodule : decoder_2to4

// File: tb/tb_decoder_2to4.sv
// -----------------------------------------------------------------------------
// tb_decoder_2to4
//   Three instances share clk/rst_n:
//     u_reg   : IN_W=2, REG_OUT=1 (main instance)
//     u_comb  : IN_W=2, REG_OUT=0
//     u_w3    : IN_W=3, REG_OUT=1
//   Registered instances are checked by monitors that pop expected values from
//   per-instance queues whenever out_valid is seen. Directed vectors use hand
//   written expected tables.
// -----------------------------------------------------------------------------
module tb_decoder_2to4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic       r_in_valid;
    logic [1:0] r_in;
    logic [3:0] r_out;
    logic       r_out_valid;

    logic       c_in_valid;
    logic [1:0] c_in;
    logic [3:0] c_out;
    logic       c_out_valid;

    logic       w_in_valid;
    logic [2:0] w_in;
    logic [7:0] w_out;
    logic       w_out_valid;

`ifdef DECODER_ONEHOT_CHK_EN
    logic r_err;
    logic c_err;
    logic w_err;
`endif

    decoder_2to4 #(.IN_W(2), .REG_OUT(1'b1)) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (r_in_valid),
        .in         (r_in),
        .out        (r_out),
        .out_valid  (r_out_valid)
`ifdef DECODER_ONEHOT_CHK_EN
        ,
        .onehot_err (r_err)
`endif
    );

    decoder_2to4 #(.IN_W(2), .REG_OUT(1'b0)) u_comb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (c_in_valid),
        .in         (c_in),
        .out        (c_out),
        .out_valid  (c_out_valid)
`ifdef DECODER_ONEHOT_CHK_EN
        ,
        .onehot_err (c_err)
`endif
    );

    decoder_2to4 #(.IN_W(3), .REG_OUT(1'b1)) u_w3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w_in_valid),
        .in         (w_in),
        .out        (w_out),
        .out_valid  (w_out_valid)
`ifdef DECODER_ONEHOT_CHK_EN
        ,
        .onehot_err (w_err)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    logic [7:0] exp8_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Hand-computed decode tables.
    logic [3:0] exp4_tbl[4];
    logic [7:0] exp8_tbl[8];

    initial begin
        exp4_tbl[0] = 4'b0001;
        exp4_tbl[1] = 4'b0010;
        exp4_tbl[2] = 4'b0100;
        exp4_tbl[3] = 4'b1000;
        exp8_tbl[0] = 8'b0000_0001;
        exp8_tbl[1] = 8'b0000_0010;
        exp8_tbl[2] = 8'b0000_0100;
        exp8_tbl[3] = 8'b0000_1000;
        exp8_tbl[4] = 8'b0001_0000;
        exp8_tbl[5] = 8'b0010_0000;
        exp8_tbl[6] = 8'b0100_0000;
        exp8_tbl[7] = 8'b1000_0000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && r_out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL reg_spurious: out_valid with out=%0h, expected no output", r_out);
                end else begin
                    e = exp_q.pop_front();
                    check("reg_out", {28'd0, r_out}, {28'd0, e});
                end
            end
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && w_out_valid) begin
                if (exp8_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL w3_spurious: out_valid with out=%0h, expected no output", w_out);
                end else begin
                    e = exp8_q.pop_front();
                    check("w3_out", {24'd0, w_out}, {24'd0, e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; the task returns 1 time
    // unit after the edge that samples them.
    task automatic reg_step(input logic v, input logic [1:0] s);
        r_in_valid = v;
        r_in       = s;
        if (v) exp_q.push_back(exp4_tbl[s]);
        @(posedge clk);
        #1;
    endtask

    task automatic w3_step(input logic v, input logic [2:0] s);
        w_in_valid = v;
        w_in       = s;
        if (v) exp8_q.push_back(exp8_tbl[s]);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b1;
        r_in_valid = 1'b1;
        r_in       = 2'd3;
        c_in_valid = 1'b0;
        c_in       = 2'd0;
        w_in_valid = 1'b0;
        w_in       = 3'd0;

        // Asynchronous reset before any clock edge (first posedge at t=5).
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_out", {28'd0, r_out}, 32'h0);
        check("rst_async_valid", {31'd0, r_out_valid}, 32'h0);
        check("rst_async_w3_out", {24'd0, w_out}, 32'h0);

        // Reset held across edges with valid input: still cleared.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_held_out", {28'd0, r_out}, 32'h0);
        check("rst_held_valid", {31'd0, r_out_valid}, 32'h0);

        r_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sweep: back-to-back valid inputs, out_valid high every cycle.
        for (int i = 0; i < 4; i++) begin
            reg_step(1'b1, 2'(i));
            check("sweep_valid", {31'd0, r_out_valid}, 32'h1);
        end

        // Hold: idle cycle keeps last value but drops out_valid.
        reg_step(1'b1, 2'd2);
        reg_step(1'b0, 2'd1);
        check("hold_out", {28'd0, r_out}, 32'h4);
        check("hold_valid", {31'd0, r_out_valid}, 32'h0);
        reg_step(1'b0, 2'd0);
        check("hold_out_2", {28'd0, r_out}, 32'h4);

        // Mid-stream reset between edges.
        reg_step(1'b1, 2'd1);
        r_in_valid = 1'b0;
        #5;                       // past the negedge where the monitor pops 0010
        rst_n = 1'b0;
        #1;
        check("midrst_out", {28'd0, r_out}, 32'h0);
        check("midrst_valid", {31'd0, r_out_valid}, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_valid", {31'd0, r_out_valid}, 32'h0);
        reg_step(1'b1, 2'd3);
        check("midrst_after_out", {28'd0, r_out}, 32'h8);
        reg_step(1'b0, 2'd0);

        // Combinational instance: same-cycle decode, zero when idle.
        for (int i = 0; i < 4; i++) begin
            c_in_valid = 1'b1;
            c_in       = 2'(i);
            #1;
            check("comb_out", {28'd0, c_out}, {28'd0, exp4_tbl[i]});
            check("comb_valid", {31'd0, c_out_valid}, 32'h1);
        end
        c_in_valid = 1'b1;
        c_in       = 2'd2;
        #1;
        check("comb_in2_out", {28'd0, c_out}, 32'h4);
        c_in_valid = 1'b0;
        #1;
        check("comb_idle_out", {28'd0, c_out}, 32'h0);
        check("comb_idle_valid", {31'd0, c_out_valid}, 32'h0);

        // IN_W=3 instance: full sweep, then a direct check of in=5.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            w3_step(1'b1, 3'(i));
        end
        w3_step(1'b1, 3'd5);
        check("w3_in5_out", {24'd0, w_out}, 32'h20);
        w3_step(1'b0, 3'd0);
        check("w3_idle_valid", {31'd0, w_out_valid}, 32'h0);

        // Drain and verify every expected value was consumed.
        repeat (3) @(posedge clk);
        #1;
        check("reg_queue_empty", exp_q.size(), 32'h0);
        check("w3_queue_empty", exp8_q.size(), 32'h0);

`ifdef DECODER_ONEHOT_CHK_EN
        check("reg_onehot_err", {31'd0, r_err}, 32'h0);
        check("comb_onehot_err", {31'd0, c_err}, 32'h0);
        check("w3_onehot_err", {31'd0, w_err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decoder_2to4
